// File: rtl/logic_unit_pipe_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// The slave modport is the unit's view; the master modport is the producer/consumer side.
interface logic_unit_pipe_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_ones;
    logic             out_parity;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_zero, out_ones, out_parity, out_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_y, out_zero, out_ones, out_parity, out_count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with valid/ready on both sides,
// a 2-entry main/skid buffer, stored result flags and a wrapping drain counter.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    logic_unit_pipe_if.slave    bus
);

    localparam int unsigned OP_W = 3;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             zero;
        logic             ones;
        logic             parity;
    } beat_t;

    localparam beat_t BEAT_RST = '{y: '0, zero: 1'b1, ones: 1'b0, parity: 1'b0};

    beat_t            beat_c;
    beat_t            m_q;
    beat_t            s_q;
    logic             m_full_q;
    logic             in_ready_q;
    logic [CNT_W-1:0] count_q;
    logic             accept_c;
    logic             drain_c;

    // Result and flags for the beat currently offered at the input.
    always_comb begin
        beat_c = BEAT_RST;
        unique case (bus.in_op)
            OP_W'(0): beat_c.y = ~bus.in_a;
            OP_W'(1): beat_c.y = bus.in_a & bus.in_b;
            OP_W'(2): beat_c.y = bus.in_a | bus.in_b;
            OP_W'(3): beat_c.y = bus.in_a ^ bus.in_b;
            OP_W'(4): beat_c.y = ~(bus.in_a & bus.in_b);
            OP_W'(5): beat_c.y = ~(bus.in_a | bus.in_b);
            OP_W'(6): beat_c.y = ~(bus.in_a ^ bus.in_b);
            default:  beat_c.y = bus.in_a;
        endcase
        beat_c.zero   = ~|beat_c.y;
        beat_c.ones   = &beat_c.y;
        beat_c.parity = ^beat_c.y;
    end

    assign accept_c = bus.in_valid & in_ready_q;
    assign drain_c  = m_full_q & bus.out_ready;

    // in_ready_q doubles as "skid entry empty", so the ready output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q        <= BEAT_RST;
            s_q        <= BEAT_RST;
            m_full_q   <= 1'b0;
            in_ready_q <= 1'b1;
        end else if (!m_full_q) begin
            if (accept_c) begin
                m_q      <= beat_c;
                m_full_q <= 1'b1;
            end
        end else if (!in_ready_q) begin
            if (drain_c) begin
                m_q        <= s_q;
                in_ready_q <= 1'b1;
            end
        end else if (drain_c) begin
            if (accept_c) begin
                m_q <= beat_c;
            end else begin
                m_full_q <= 1'b0;
            end
        end else if (accept_c) begin
            s_q        <= beat_c;
            in_ready_q <= 1'b0;
        end
    end

    // Completed-transaction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (drain_c) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = m_full_q;
    assign bus.out_y      = m_q.y;
    assign bus.out_zero   = m_q.zero;
    assign bus.out_ones   = m_q.ones;
    assign bus.out_parity = m_q.parity;
    assign bus.out_count  = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: a 4-bit instance for directed cases and a 16-bit,
// 2-bit-counter instance for wrap and random traffic, both tracked by a queue model.
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(4),  .CNT_W(8)) a_if ();
    logic_unit_pipe_if #(.WIDTH(16), .CNT_W(2)) b_if ();

    logic_unit_pipe #(.WIDTH(4),  .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
    logic_unit_pipe #(.WIDTH(16), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

    typedef struct packed {
        logic [15:0] y;
        logic        z;
        logic        o;
        logic        p;
    } exp_t;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected result straight from the operation table, masked to the width.
    function automatic exp_t mk(input logic [2:0] op, input logic [15:0] a,
                                input logic [15:0] b, input int w);
        logic [15:0] m;
        logic [15:0] y;
        exp_t e;
        m = 16'((32'd1 << w) - 32'd1);
        case (op)
            3'd0: y = ~a;
            3'd1: y = a & b;
            3'd2: y = a | b;
            3'd3: y = a ^ b;
            3'd4: y = ~(a & b);
            3'd5: y = ~(a | b);
            3'd6: y = ~(a ^ b);
            default: y = a;
        endcase
        y   = y & m;
        e.y = y;
        e.z = (y == 16'd0);
        e.o = (y == m);
        e.p = ^y;
        return e;
    endfunction

    // Model: the unit behaves as an in-order FIFO of depth two, ready while not full.
    exp_t        qa[$];
    exp_t        qb[$];
    int unsigned cnt_a, cnt_b, nacc_b;
    bit          acc_a, drn_a, acc_b, drn_b;
    exp_t        e_a, e_b, junk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            cnt_a = 0;
        end else begin
            acc_a = a_if.in_valid && (qa.size() < 2);
            drn_a = a_if.out_ready && (qa.size() > 0);
            e_a   = mk(a_if.in_op, 16'(a_if.in_a), 16'(a_if.in_b), 4);
            if (drn_a) begin
                junk  = qa.pop_front();
                cnt_a = (cnt_a + 1) % 256;
            end
            if (acc_a) qa.push_back(e_a);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qb.delete();
            cnt_b = 0;
        end else begin
            acc_b = b_if.in_valid && (qb.size() < 2);
            drn_b = b_if.out_ready && (qb.size() > 0);
            e_b   = mk(b_if.in_op, b_if.in_a, b_if.in_b, 16);
            if (drn_b) begin
                junk  = qb.pop_front();
                cnt_b = (cnt_b + 1) % 4;
            end
            if (acc_b) begin
                qb.push_back(e_b);
                nacc_b++;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("a_in_ready",  32'(a_if.in_ready),  32'(qa.size() < 2));
            chk("a_out_valid", 32'(a_if.out_valid), 32'(qa.size() > 0));
            chk("a_count",     32'(a_if.out_count), cnt_a);
            if (qa.size() > 0) begin
                chk("a_y",      32'(a_if.out_y),      32'(qa[0].y));
                chk("a_zero",   32'(a_if.out_zero),   32'(qa[0].z));
                chk("a_ones",   32'(a_if.out_ones),   32'(qa[0].o));
                chk("a_parity", 32'(a_if.out_parity), 32'(qa[0].p));
            end
            chk("b_in_ready",  32'(b_if.in_ready),  32'(qb.size() < 2));
            chk("b_out_valid", 32'(b_if.out_valid), 32'(qb.size() > 0));
            chk("b_count",     32'(b_if.out_count), cnt_b);
            if (qb.size() > 0) begin
                chk("b_y",      32'(b_if.out_y),      32'(qb[0].y));
                chk("b_zero",   32'(b_if.out_zero),   32'(qb[0].z));
                chk("b_ones",   32'(b_if.out_ones),   32'(qb[0].o));
                chk("b_parity", 32'(b_if.out_parity), 32'(qb[0].p));
            end
        end
    end

    logic [3:0] sweep_lit [8] = '{4'b0101, 4'b0010, 4'b1110, 4'b1100,
                                  4'b1101, 4'b0001, 4'b0011, 4'b1010};
    logic [1:0] wrap_lit  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    int unsigned cyc;

    task automatic reset_lits(input string tag);
        chk({tag, "_in_ready"},  32'(a_if.in_ready),   32'd1);
        chk({tag, "_out_valid"}, 32'(a_if.out_valid),  32'd0);
        chk({tag, "_count"},     32'(a_if.out_count),  32'd0);
    endtask

    initial begin
        a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
        a_if.in_a = '0; a_if.in_b = '0; a_if.in_op = '0;
        b_if.in_valid = 1'b0; b_if.out_ready = 1'b0;
        b_if.in_a = '0; b_if.in_b = '0; b_if.in_op = '0;
        nacc_b = 0;

        repeat (2) @(negedge clk);
        reset_lits("rst");
        chk("rst_y",      32'(a_if.out_y),      32'd0);
        chk("rst_zero",   32'(a_if.out_zero),   32'd1);
        chk("rst_ones",   32'(a_if.out_ones),   32'd0);
        chk("rst_parity", 32'(a_if.out_parity), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Op sweep, back-to-back with out_ready held high.
        a_if.out_ready = 1'b1;
        a_if.in_valid  = 1'b1;
        a_if.in_a      = 4'b1010;
        a_if.in_b      = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            a_if.in_op = 3'(i);
            @(negedge clk);
            chk("sweep_y", 32'(a_if.out_y), 32'(sweep_lit[i]));
        end
        a_if.in_valid = 1'b0;
        @(negedge clk);
        chk("sweep_count", 32'(a_if.out_count), 32'd8);

        // Flags.
        a_if.in_valid = 1'b1;
        a_if.in_a = 4'b0000; a_if.in_op = 3'd7;
        @(negedge clk);
        chk("flag_zero",   32'(a_if.out_zero),   32'd1);
        chk("flag_ones0",  32'(a_if.out_ones),   32'd0);
        chk("flag_par0",   32'(a_if.out_parity), 32'd0);
        a_if.in_a = 4'b0000; a_if.in_op = 3'd0;
        @(negedge clk);
        chk("flag_not_y",  32'(a_if.out_y),      32'hF);
        chk("flag_ones1",  32'(a_if.out_ones),   32'd1);
        chk("flag_par1",   32'(a_if.out_parity), 32'd0);
        a_if.in_a = 4'b0001; a_if.in_op = 3'd7;
        @(negedge clk);
        chk("flag_par_odd", 32'(a_if.out_parity), 32'd1);
        a_if.in_valid = 1'b0;
        @(negedge clk);

        // Backpressure: three beats offered with the consumer stalled.
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_op     = 3'd7;
        a_if.in_a      = 4'b0001;
        @(negedge clk);
        chk("bp_ready1", 32'(a_if.in_ready), 32'd1);
        a_if.in_a = 4'b0010;
        @(negedge clk);
        chk("bp_ready0", 32'(a_if.in_ready), 32'd0);
        a_if.in_a = 4'b0100;
        @(negedge clk);
        chk("bp_hold_y",   32'(a_if.out_y),    32'h1);
        chk("bp_hold_rdy", 32'(a_if.in_ready), 32'd0);
        a_if.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_y2",     32'(a_if.out_y),    32'h2);
        chk("bp_rdy_up", 32'(a_if.in_ready), 32'd1);
        @(negedge clk);
        chk("bp_y3", 32'(a_if.out_y), 32'h4);
        a_if.in_valid = 1'b0;
        @(negedge clk);

        // Reset with both entries occupied.
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_a      = 4'b1000;
        repeat (2) @(negedge clk);
        a_if.in_valid = 1'b0;
        chk("mid_full_rdy", 32'(a_if.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1 reset_lits("mid");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        a_if.out_ready = 1'b1;
        a_if.in_valid  = 1'b1;
        a_if.in_a      = 4'b0011;
        @(negedge clk);
        chk("mid_lat_valid", 32'(a_if.out_valid), 32'd1);
        chk("mid_lat_y",     32'(a_if.out_y),     32'h3);
        a_if.in_valid = 1'b0;
        @(negedge clk);

        // Counter wrap on the 2-bit counter instance.
        b_if.out_ready = 1'b1;
        b_if.in_valid  = 1'b1;
        b_if.in_a      = 16'h1234;
        b_if.in_op     = 3'd7;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wrap_count", 32'(b_if.out_count), 32'(wrap_lit[i]));
        end
        b_if.in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Random traffic until 10k beats have been accepted.
        nacc_b = 0;
        cyc    = 0;
        while (nacc_b < 10000 && cyc < 80000) begin
            b_if.in_valid  = ($urandom_range(0, 9) < 7);
            b_if.out_ready = ($urandom_range(0, 9) < 6);
            b_if.in_a      = 16'($urandom);
            b_if.in_b      = 16'($urandom);
            b_if.in_op     = 3'($urandom);
            @(negedge clk);
            cyc++;
        end
        chk("rand_budget", 32'(nacc_b >= 10000), 32'd1);
        b_if.in_valid  = 1'b0;
        b_if.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("rand_drained", 32'(b_if.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
